kpn_channel_arbiter: RTL and testbench
======================================

KPN_CHANNEL_ARBITER -- requirements
Module: kpn_channel_arbiter

Interface
REQ-001 The block SHALL have parameter BITS_NUMBER, default 16, giving the token data width.
REQ-002 The block SHALL have parameter FIFO_ELEMENTS, default 5, giving the channel depth as 2**FIFO_ELEMENTS tokens.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on the rising edge only.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Ports req_0 and req_1, input, 1 bit each: producer write requests, held high until the matching grant is seen.
REQ-006 Ports data_0 and data_1, input, BITS_NUMBER bits each: producer tokens, held stable while the matching request is high.
REQ-007 Port rd_req, input, 1 bit: consumer read request, held high until rd_gnt is seen.
REQ-008 Ports gnt_0 and gnt_1, output, 1 bit each: one-cycle write-grant pulses to the producers.
REQ-009 Port rd_gnt, output, 1 bit: one-cycle read-grant pulse to the consumer.
REQ-010 Ports fifo_wr and fifo_rd, output, 1 bit each: one-cycle write and read strobes to the attached channel FIFO.
REQ-011 Port fifo_data, output, BITS_NUMBER bits: the token being written to the channel FIFO.
REQ-012 Port count, output, FIFO_ELEMENTS+1 bits: current channel occupancy.
REQ-013 Ports full and empty, output, 1 bit each: full is count==2**FIFO_ELEMENTS; empty is count==0.

Function
REQ-014 All outputs SHALL be registered; a request sampled at edge N SHALL produce its grant and strobe during cycle N+1 (latency 1).
REQ-015 Eligible writers at edge N SHALL be those with req_x=1 and gnt_x=0 (masking prevents a double grant on a still-high request).
REQ-016 A write SHALL be granted only when full=0 at edge N; while full, requests stay pending with no grant and no fifo_wr.
REQ-017 If exactly one writer is eligible, that writer SHALL be granted.
REQ-018 If both writers are eligible, the one not granted most recently SHALL win (round-robin); after reset, writer 0 has priority.
REQ-019 The last-winner pointer SHALL update only on an actual write grant.
REQ-020 On a write grant: gnt_x=1, fifo_wr=1 and fifo_data=data_x of the winner, all for exactly one cycle.
REQ-021 fifo_data SHALL hold its previous value when fifo_wr=0.
REQ-022 A read SHALL be granted when rd_req=1, rd_gnt=0 and empty=0 at edge N: rd_gnt=1 and fifo_rd=1 for one cycle.
REQ-023 rd_req while empty SHALL stay pending with no strobe, and SHALL be granted one cycle after count becomes nonzero.
REQ-024 A read and a write granted at the same edge SHALL both proceed, with count unchanged.
REQ-025 A write alone SHALL increment count and a read alone SHALL decrement count, both at the same edge the grant is registered.
REQ-026 count SHALL never exceed 2**FIFO_ELEMENTS nor go below 0.
REQ-027 A write SHALL NOT be granted while full even if a read is granted at the same edge; this is a full-bypass prohibition.
REQ-028 At most one write grant and one read grant SHALL occur per cycle.

Reset
REQ-029 With reset=1 at an edge: gnt_0, gnt_1, rd_gnt, fifo_wr and fifo_rd SHALL be 0; fifo_data=0; count=0; empty=1; full=0; round-robin priority returns to writer 0.
REQ-030 Reset SHALL override all requests in the same cycle, including mid-transfer, and any pending request SHALL be re-arbitrated from scratch afterwards.

Verification
REQ-031 Reset, then req_0=1 with data_0=16'h00A5 -> next cycle gnt_0=1, fifo_wr=1, fifo_data=16'h00A5, count=1, empty=0.
REQ-032 Both requesters held high for 4 cycles with data_0=1 and data_1=2 -> grants alternate 0,1,0,1 with no back-to-back grant to the same requester; count=4.
REQ-033 32 writes with DEPTH=32 -> full=1 and count=32; a 33rd req_0 gets no grant; one read then releases it, count returns to 32 after two cycles.
REQ-034 rd_req=1 on empty -> no rd_gnt; then one write -> rd_gnt one cycle after count=1, count back to 0, empty=1.
REQ-035 count=5 with read and write granted at the same edge -> count stays 5, fifo_wr=fifo_rd=1.
REQ-036 reset asserted at count=7 while both requests are high -> count=0, all strobes 0; after release writer 0 is granted first.

Source files
------------

// File: rtl/kpn_channel_arbiter.sv
// Two-producer / one-consumer arbiter for a KPN channel FIFO. Latency: 1 cycle, request to grant/strobe.
// Backpressure: writes stall while full, reads stall while empty; the requests stay pending meanwhile.
module kpn_channel_arbiter #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_0,
  input  logic                     req_1,
  input  logic [BITS_NUMBER-1:0]   data_0,
  input  logic [BITS_NUMBER-1:0]   data_1,
  input  logic                     rd_req,
  output logic                     gnt_0,
  output logic                     gnt_1,
  output logic                     rd_gnt,
  output logic                     fifo_wr,
  output logic                     fifo_rd,
  output logic [BITS_NUMBER-1:0]   fifo_data,
  output logic [FIFO_ELEMENTS:0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam logic [FIFO_ELEMENTS:0] DEPTH = {1'b1, {FIFO_ELEMENTS{1'b0}}};

  logic                   elig_0;
  logic                   elig_1;
  logic                   wr_en;
  logic                   pick_1;
  logic                   rd_en;
  logic                   prio_1;
  logic [FIFO_ELEMENTS:0] count_nxt;

  // A request whose grant is currently on the wire is masked so it is not granted twice.
  always_comb begin
    elig_0    = req_0 & ~gnt_0;
    elig_1    = req_1 & ~gnt_1;
    wr_en     = ~full & (elig_0 | elig_1);
    pick_1    = elig_1 & (~elig_0 | prio_1);
    rd_en     = rd_req & ~rd_gnt & ~empty;
    count_nxt = count;
    if (wr_en && !rd_en)
      count_nxt = count + 1'b1;
    else if (rd_en && !wr_en)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_0     <= 1'b0;
      gnt_1     <= 1'b0;
      rd_gnt    <= 1'b0;
      fifo_wr   <= 1'b0;
      fifo_rd   <= 1'b0;
      fifo_data <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      prio_1    <= 1'b0;
    end else begin
      gnt_0   <= wr_en & ~pick_1;
      gnt_1   <= wr_en & pick_1;
      fifo_wr <= wr_en;
      rd_gnt  <= rd_en;
      fifo_rd <= rd_en;
      count   <= count_nxt;
      full    <= (count_nxt == DEPTH);
      empty   <= (count_nxt == '0);
      // Priority flips to the loser only when a write actually goes through.
      if (wr_en) begin
        fifo_data <= pick_1 ? data_1 : data_0;
        prio_1    <= ~pick_1;
      end
    end
  end

endmodule

// File: tb/tb_kpn_channel_arbiter.sv
// Directed bench for kpn_channel_arbiter: inputs driven 1 time unit after the rising edge, outputs checked there too.
module tb_kpn_channel_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_0, req_1, rd_req;
  logic [15:0] data_0, data_1;
  logic        gnt_0, gnt_1, rd_gnt, fifo_wr, fifo_rd, full, empty;
  logic [15:0] fifo_data;
  logic [5:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  kpn_channel_arbiter #(.BITS_NUMBER(16), .FIFO_ELEMENTS(5)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .data_0(data_0), .data_1(data_1),
    .rd_req(rd_req), .gnt_0(gnt_0), .gnt_1(gnt_1), .rd_gnt(rd_gnt),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes in one word: {gnt_0, gnt_1, fifo_wr, rd_gnt, fifo_rd}
  function automatic logic [31:0] strobes();
    return {27'd0, gnt_0, gnt_1, fifo_wr, rd_gnt, fifo_rd};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_0 = 0; req_1 = 0; rd_req = 0; data_0 = '0; data_1 = '0;
    tick();
    tick();
    chk("rst_strobes", strobes(), 32'h0);
    chk("rst_data",    fifo_data, 32'h0);
    chk("rst_count",   count, 32'd0);
    chk("rst_empty",   empty, 32'd1);
    chk("rst_full",    full,  32'd0);
    reset = 1'b0;

    // Single write from producer 0.
    req_0 = 1; data_0 = 16'h00A5;
    tick();
    chk("w1_strobes", strobes(), 32'b10100);
    chk("w1_data",    fifo_data, 32'h00A5);
    chk("w1_count",   count, 32'd1);
    chk("w1_empty",   empty, 32'd0);
    req_0 = 0; data_0 = 16'h1234;
    tick();
    chk("w1_idle_strobes", strobes(), 32'b00000);
    chk("w1_hold_data",    fifo_data, 32'h00A5);
    chk("w1_hold_count",   count, 32'd1);

    // Round robin with both producers held high.
    do_reset();
    req_0 = 1; req_1 = 1; data_0 = 16'd1; data_1 = 16'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt", {gnt_0, gnt_1}, (i % 2 == 0) ? 32'b10 : 32'b01);
      chk("rr_data", fifo_data, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_count", count, i + 1);
    end
    req_0 = 0; req_1 = 0;
    tick();
    chk("rr_idle", strobes(), 32'h0);
    chk("rr_count_final", count, 32'd4);

    // Bring count to 5, then simultaneous read and write.
    req_0 = 1; data_0 = 16'h0055;
    tick();
    chk("c5_gnt0", gnt_0, 32'd1);
    chk("c5_count", count, 32'd5);
    req_0 = 0;
    tick();
    req_0 = 1; rd_req = 1;
    tick();
    chk("rw_strobes", strobes(), 32'b10111);
    chk("rw_count",   count, 32'd5);
    req_0 = 0; rd_req = 0;
    tick();

    // Fill to 32 with both writers streaming.
    req_0 = 1; req_1 = 1;
    for (int i = 0; i < 27; i++) begin
      tick();
      chk("fill_wr", fifo_wr, 32'd1);
    end
    req_1 = 0;
    chk("fill_count", count, 32'd32);
    chk("fill_full",  full,  32'd1);
    // req_0 stays high: blocked while full.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_blocked", strobes(), 32'h0);
      chk("full_count",   count, 32'd32);
    end
    rd_req = 1;
    tick();
    chk("full_rd_strobes", strobes(), 32'b00011);
    chk("full_rd_count",   count, 32'd31);
    chk("full_rd_full",    full,  32'd0);
    rd_req = 0;
    tick();
    chk("refill_strobes", strobes(), 32'b10100);
    chk("refill_count",   count, 32'd32);
    chk("refill_full",    full,  32'd1);
    req_0 = 0;

    // Reset mid-stream at count 7 with both requests high.
    do_reset();
    req_0 = 1; req_1 = 1; data_0 = 16'hAAAA; data_1 = 16'hBBBB;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_count", count, 32'd7);
    chk("pre_rst_gnt",   {gnt_0, gnt_1}, 32'b10);
    reset = 1;
    tick();
    chk("mid_rst_strobes", strobes(), 32'h0);
    chk("mid_rst_count",   count, 32'd0);
    chk("mid_rst_empty",   empty, 32'd1);
    chk("mid_rst_data",    fifo_data, 32'h0);
    reset = 0;
    tick();
    chk("post_rst_gnt",  {gnt_0, gnt_1}, 32'b10);
    chk("post_rst_data", fifo_data, 32'hAAAA);
    req_0 = 0; req_1 = 0;

    // Read pending on empty, released by a single write.
    rd_req = 1;
    tick();
    chk("drain_rd", rd_gnt, 32'd1);
    chk("drain_count", count, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("empty_rd_blocked", strobes(), 32'h0);
      chk("empty_flag", empty, 32'd1);
    end
    req_0 = 1; data_0 = 16'h0C0C;
    tick();
    chk("er_wr_strobes", strobes(), 32'b10100);
    chk("er_wr_count",   count, 32'd1);
    req_0 = 0;
    tick();
    chk("er_rd_strobes", strobes(), 32'b00011);
    chk("er_rd_count",   count, 32'd0);
    chk("er_rd_empty",   empty, 32'd1);
    rd_req = 0;
    tick();
    chk("er_idle", strobes(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
